seven_segment_mux: RTL

SEVEN_SEGMENT_MUX -- requirements
Module: seven_segment_mux

---
 rtl/seven_segment_mux.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/seven_segment_mux.sv
// Multiplexed seven-segment display driver with frame-synchronous double buffering.
// Optional leading-zero blanking is built when macro SEVSEG_LZB_EN is defined.
module seven_segment_mux #(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned DIV        = 1000,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   bcd,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic [DIGITS-1:0]     dsen,
    output logic                  frame_done
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic                  boundary;

    logic [4*DIGITS-1:0]   sh_bcd, act_bcd;
    logic [DIGITS-1:0]     sh_dp, act_dp;
    logic [DIGITS-1:0]     sh_blank, act_blank;
    logic                  pending;

    logic [DIGITS-1:0]     eff_blank;
    logic [3:0]            cur_bcd;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [DIGITS-1:0]     dsen_n;

    logic [6:0]            seg_r;
    logic                  dp_r;
    logic [DIGITS-1:0]     dsen_r;
    logic                  fd_r;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h7E;  4'h1: s = 7'h30;  4'h2: s = 7'h6D;  4'h3: s = 7'h79;
            4'h4: s = 7'h33;  4'h5: s = 7'h5B;  4'h6: s = 7'h5F;  4'h7: s = 7'h70;
            4'h8: s = 7'h7F;  4'h9: s = 7'h7B;  4'hA: s = 7'h77;  4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;  4'hD: s = 7'h3D;  4'hE: s = 7'h4F;  default: s = 7'h47;
        endcase
        return s;
    endfunction

    assign boundary = (cnt == CNT_LAST) && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A load landing on the boundary bypasses the shadow so it is never a frame late.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_bcd    <= '0;
            sh_dp     <= '0;
            sh_blank  <= '0;
            act_bcd   <= '0;
            act_dp    <= '0;
            act_blank <= '0;
            pending   <= 1'b0;
        end else if (boundary && load) begin
            act_bcd   <= bcd;
            act_dp    <= dp;
            act_blank <= blank;
            pending   <= 1'b0;
        end else if (boundary && pending) begin
            act_bcd   <= sh_bcd;
            act_dp    <= sh_dp;
            act_blank <= sh_blank;
            pending   <= 1'b0;
        end else if (load) begin
            sh_bcd    <= bcd;
            sh_dp     <= dp;
            sh_blank  <= blank;
            pending   <= 1'b1;
        end
    end

`ifdef SEVSEG_LZB_EN
    // Walk down from the top digit; blanking stops at the first nonzero or dp digit.
    always_comb begin
        logic zrun;
        eff_blank = act_blank;
        zrun      = 1'b1;
        for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
            zrun = zrun && (act_bcd[4*k +: 4] == 4'h0) && !act_dp[k];
            if (zrun) eff_blank[k] = 1'b1;
        end
    end
`else
    assign eff_blank = act_blank;
`endif

    always_comb begin
        cur_bcd   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        dsen_n    = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (32'(idx) == k) begin
                cur_bcd   = act_bcd[4*k +: 4];
                cur_dp    = act_dp[k];
                cur_blank = eff_blank[k];
                dsen_n[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r  <= '0;
            dp_r   <= 1'b0;
            dsen_r <= '0;
            fd_r   <= 1'b0;
        end else begin
            seg_r  <= cur_blank ? '0 : hex7(cur_bcd);
            dp_r   <= cur_dp && !cur_blank;
            dsen_r <= dsen_n;
            fd_r   <= boundary;
        end
    end

    assign seg        = ACTIVE_LOW ? ~seg_r  : seg_r;
    assign seg_dp     = ACTIVE_LOW ? ~dp_r   : dp_r;
    assign dsen       = ACTIVE_LOW ? ~dsen_r : dsen_r;
    assign frame_done = fd_r;

endmodule
